// File: rtl/cache_line_refill.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cache_line_refill
//  Description : Blocking miss handler for a set-associative cache. Accepts
//                one miss {tag,index,victim} at a time, writes the victim
//                line back word-by-word when dirty, fetches the new line
//                word-by-word over a req/ack memory port, then pulses a
//                one-cycle fill write into the selected way.
//  Ports       : clk/rst                 clock, synchronous active-high reset
//                i_miss_* / i_victim_*   miss request (valid/ready handshake)
//                o_mem_* / i_mem_*       registered req/ack memory port
//                o_fill_*                one-cycle fill write to the cache
//                o_busy                  a miss is in progress
//  Revision    : 1.0  initial release
// ============================================================================
module cache_line_refill #(
    parameter int  LINE_SIZE_BYTES = 64,
    parameter int  DATA_WIDTH      = 32,
    parameter int  TAG_BITS        = 18,
    parameter int  CACHE_LINES     = 256,
    parameter int  WAYS            = 4,
    parameter int  ADDRESS_WIDTH   = 32,
    localparam int INDEX_WIDTH     = $clog2(CACHE_LINES),
    localparam int WAY_W           = $clog2(WAYS),
    localparam int LINE_BITS       = LINE_SIZE_BYTES * 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_miss_valid,
    output logic                     o_miss_ready,
    input  logic [TAG_BITS-1:0]      i_miss_tag,
    input  logic [INDEX_WIDTH-1:0]   i_miss_index,
    input  logic [WAY_W-1:0]         i_victim_way,
    input  logic                     i_victim_dirty,
    input  logic [TAG_BITS-1:0]      i_victim_tag,
    input  logic [LINE_BITS-1:0]     i_victim_line,
    output logic                     o_mem_req,
    output logic                     o_mem_we,
    output logic [ADDRESS_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0]    o_mem_wdata,
    input  logic                     i_mem_ack,
    input  logic [DATA_WIDTH-1:0]    i_mem_rdata,
    output logic                     o_fill_valid,
    output logic [INDEX_WIDTH-1:0]   o_fill_index,
    output logic [WAY_W-1:0]         o_fill_way,
    output logic [TAG_BITS-1:0]      o_fill_tag,
    output logic [LINE_BITS-1:0]     o_fill_line,
    output logic                     o_busy
);

    localparam int WORDS    = LINE_BITS / DATA_WIDTH;
    localparam int WCNT_W   = $clog2(WORDS);
    localparam int LANE_W   = $clog2(DATA_WIDTH / 8);
    localparam int OFFSET_W = $clog2(LINE_SIZE_BYTES);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FETCH     = 2'd2,
        S_FILL      = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [WCNT_W-1:0]        wcnt_q, wcnt_d;
    logic [TAG_BITS-1:0]      tag_q, tag_d;
    logic [INDEX_WIDTH-1:0]   index_q, index_d;
    logic [WAY_W-1:0]         way_q, way_d;
    logic [TAG_BITS-1:0]      vtag_q, vtag_d;
    logic [LINE_BITS-1:0]     vline_q, vline_d;
    logic [LINE_BITS-1:0]     buf_q, buf_d;
    logic                     mem_req_q, mem_req_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic                     fill_valid_q, fill_valid_d;
    logic [OFFSET_W-1:0]      offset_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wcnt_q       <= '0;
            tag_q        <= '0;
            index_q      <= '0;
            way_q        <= '0;
            vtag_q       <= '0;
            vline_q      <= '0;
            buf_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            fill_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            tag_q        <= tag_d;
            index_q      <= index_d;
            way_q        <= way_d;
            vtag_q       <= vtag_d;
            vline_q      <= vline_d;
            buf_q        <= buf_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            fill_valid_q <= fill_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        tag_d   = tag_q;
        index_d = index_q;
        way_d   = way_q;
        vtag_d  = vtag_q;
        vline_d = vline_q;
        buf_d   = buf_q;

        case (state_q)
            S_IDLE: begin
                // o_miss_ready is high in IDLE, so valid alone completes the handshake.
                if (i_miss_valid) begin
                    tag_d   = i_miss_tag;
                    index_d = i_miss_index;
                    way_d   = i_victim_way;
                    vtag_d  = i_victim_tag;
                    vline_d = i_victim_line;
                    wcnt_d  = '0;
                    state_d = i_victim_dirty ? S_WRITEBACK : S_FETCH;
                end
            end
            S_WRITEBACK: begin
                if (i_mem_ack) begin
                    // Counter wraps to 0 on the last word, ready for the fetch pass.
                    wcnt_d = wcnt_q + WCNT_W'(1);
                    if (wcnt_q == LAST_WORD) begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (i_mem_ack) begin
                    buf_d[int'(wcnt_q) * DATA_WIDTH +: DATA_WIDTH] = i_mem_rdata;
                    wcnt_d = wcnt_q + WCNT_W'(1);
                    if (wcnt_q == LAST_WORD) begin
                        state_d = S_FILL;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory-port and fill outputs are computed from the next state so they
    // can be registered without adding a cycle of latency; while a word is
    // stalled the inputs to this logic are unchanged, so the port holds.
    always_comb begin
        offset_d     = OFFSET_W'(wcnt_d) << LANE_W;
        mem_req_d    = (state_d == S_WRITEBACK) || (state_d == S_FETCH);
        mem_we_d     = (state_d == S_WRITEBACK);
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        fill_valid_d = (state_d == S_FILL);
        if (state_d == S_WRITEBACK) begin
            mem_addr_d  = {vtag_d, index_d, offset_d};
            mem_wdata_d = vline_d[int'(wcnt_d) * DATA_WIDTH +: DATA_WIDTH];
        end else if (state_d == S_FETCH) begin
            mem_addr_d  = {tag_d, index_d, offset_d};
        end
    end

    assign o_miss_ready = (state_q == S_IDLE);
    assign o_busy       = (state_q != S_IDLE);
    assign o_mem_req    = mem_req_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_wdata  = mem_wdata_q;
    assign o_fill_valid = fill_valid_q;
    assign o_fill_index = index_q;
    assign o_fill_way   = way_q;
    assign o_fill_tag   = tag_q;
    assign o_fill_line  = buf_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_line_refill.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cache_line_refill
//  Description : Self-checking bench for cache_line_refill. A memory
//                responder drives ack/rdata and logs every accepted word;
//                each test compares the log and the fill pulse against a
//                transaction-level model of the miss sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cache_line_refill;

    localparam int DW    = 32;
    localparam int IW    = 8;
    localparam int OFFW  = 6;
    localparam int WORDS = 16;
    localparam int LB    = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_miss_valid;
    logic          o_miss_ready;
    logic [17:0]   i_miss_tag;
    logic [7:0]    i_miss_index;
    logic [1:0]    i_victim_way;
    logic          i_victim_dirty;
    logic [17:0]   i_victim_tag;
    logic [LB-1:0] i_victim_line;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [31:0]   o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic          i_mem_ack;
    logic [DW-1:0] i_mem_rdata;
    logic          o_fill_valid;
    logic [7:0]    o_fill_index;
    logic [1:0]    o_fill_way;
    logic [17:0]   o_fill_tag;
    logic [LB-1:0] o_fill_line;
    logic          o_busy;

    cache_line_refill dut (
        .clk(clk), .rst(rst),
        .i_miss_valid(i_miss_valid), .o_miss_ready(o_miss_ready),
        .i_miss_tag(i_miss_tag), .i_miss_index(i_miss_index),
        .i_victim_way(i_victim_way), .i_victim_dirty(i_victim_dirty),
        .i_victim_tag(i_victim_tag), .i_victim_line(i_victim_line),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_fill_valid(o_fill_valid), .o_fill_index(o_fill_index), .o_fill_way(o_fill_way),
        .o_fill_tag(o_fill_tag), .o_fill_line(o_fill_line), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ack_mode = 0;   // 0: ack always high, 1: every 3rd req cycle, 2: random
    int stall_cnt = 0;
    int hold_err = 0;

    txn_t          txq[$];
    txn_t          exp_q[$];
    int            acc_q[$];
    int            fill_cyc_q[$];
    logic [LB-1:0] fill_line_q[$];
    logic [7:0]    fill_idx_q[$];
    logic [1:0]    fill_way_q[$];
    logic [17:0]   fill_tag_q[$];

    logic          p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0, p_rst = 1'b1;
    logic [31:0]   p_addr = '0, p_wd = '0;
    logic          a_now;
    logic [31:0]   rd_now;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder and observer: samples outputs mid-cycle, then drives ack/rdata.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!p_rst && p_req && !p_ack &&
                (o_mem_req !== 1'b1 || o_mem_we !== p_we || o_mem_addr !== p_addr || o_mem_wdata !== p_wd))
                hold_err++;
            if (!rst && i_miss_valid && o_miss_ready) acc_q.push_back(cyc);
            if (o_fill_valid) begin
                fill_cyc_q.push_back(cyc);
                fill_line_q.push_back(o_fill_line);
                fill_idx_q.push_back(o_fill_index);
                fill_way_q.push_back(o_fill_way);
                fill_tag_q.push_back(o_fill_tag);
            end
            case (ack_mode)
                0:       a_now = 1'b1;
                1:       a_now = o_mem_req && (stall_cnt == 2);
                default: a_now = 1'($urandom_range(0, 1));
            endcase
            if (ack_mode == 1 && o_mem_req) stall_cnt = (stall_cnt == 2) ? 0 : stall_cnt + 1;
            rd_now = $urandom;
            i_mem_ack   = a_now;
            i_mem_rdata = rd_now;
            if (!rst && o_mem_req && a_now)
                txq.push_back('{o_mem_we, o_mem_addr, o_mem_we ? o_mem_wdata : rd_now});
            p_req = o_mem_req; p_ack = a_now; p_we = o_mem_we;
            p_addr = o_mem_addr; p_wd = o_mem_wdata; p_rst = rst;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] word_addr(input logic [17:0] t, input logic [7:0] ix, input int w);
        return (32'(t) << (IW + OFFW)) | (32'(ix) << OFFW) | 32'(w * (DW / 8));
    endfunction

    // Expected word stream of one miss: optional write-back, then the fetch.
    task automatic model_miss(input logic [17:0] t, input logic [7:0] ix, input logic d,
                              input logic [17:0] vt, input logic [LB-1:0] vl);
        txn_t e;
        exp_q.delete();
        if (d) begin
            for (int i = 0; i < WORDS; i++) begin
                e.we = 1'b1; e.addr = word_addr(vt, ix, i); e.data = vl[i*DW +: DW];
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < WORDS; i++) begin
            e.we = 1'b0; e.addr = word_addr(t, ix, i); e.data = '0;
            exp_q.push_back(e);
        end
    endtask

    // The filled line is the read data the memory returned, in order, low word first.
    function automatic logic [LB-1:0] model_line();
        logic [LB-1:0] l = '0;
        int k = 0;
        foreach (txq[i]) begin
            if (!txq[i].we && k < WORDS) begin
                l[k*DW +: DW] = txq[i].data;
                k++;
            end
        end
        return l;
    endfunction

    function automatic int diff_txns();
        int bad = 0;
        if (txq.size() != exp_q.size()) bad++;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= txq.size()) bad++;
            else if (txq[i].we !== exp_q[i].we || txq[i].addr !== exp_q[i].addr ||
                     (exp_q[i].we && txq[i].data !== exp_q[i].data)) bad++;
        end
        return bad;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_obs();
        txq.delete(); acc_q.delete(); fill_cyc_q.delete(); fill_line_q.delete();
        fill_idx_q.delete(); fill_way_q.delete(); fill_tag_q.delete();
        hold_err = 0; stall_cnt = 0;
    endtask

    task automatic start_miss(input logic [17:0] t, input logic [7:0] ix, input logic [1:0] w,
                              input logic d, input logic [17:0] vt, input logic [LB-1:0] vl,
                              input bit hold_valid);
        @(negedge clk);
        i_miss_tag = t; i_miss_index = ix; i_victim_way = w;
        i_victim_dirty = d; i_victim_tag = vt; i_victim_line = vl;
        i_miss_valid = 1'b1;
        if (!hold_valid) begin
            @(negedge clk);
            i_miss_valid = 1'b0;
        end
    endtask

    task automatic wait_fills(input int n, input int budget, output bit ok);
        int k = 0;
        while (fill_cyc_q.size() < n && k < budget) begin
            @(negedge clk); #2; k++;
        end
        ok = (fill_cyc_q.size() >= n);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        n_checks++; if (o_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", o_mem_req); end
        n_checks++; if (o_mem_we !== 1'b0 || o_mem_addr !== 32'h0 || o_mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_mem: got we=%b addr=%h wdata=%h expected 0/0/0", o_mem_we, o_mem_addr, o_mem_wdata); end
        n_checks++; if (o_fill_valid !== 1'b0 || o_busy !== 1'b0 || o_miss_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ctrl: got fill=%b busy=%b ready=%b expected 0/0/1", o_fill_valid, o_busy, o_miss_ready); end
        n_checks++; if (o_fill_line !== '0 || o_fill_tag !== '0 || o_fill_index !== '0 || o_fill_way !== '0) begin
            n_fail++; $display("FAIL reset_fill_regs: got tag=%h idx=%h way=%h expected 0", o_fill_tag, o_fill_index, o_fill_way); end
        rst = 1'b0;
        @(negedge clk); #2;
        n_checks++; if (o_miss_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL after_reset_ready: got ready=%b busy=%b expected 1/0", o_miss_ready, o_busy); end
    endtask

    task automatic test_clean_miss();
        bit ok; int bad;
        ack_mode = 0; clear_obs();
        model_miss(18'h2A, 8'h05, 1'b0, 18'h0, '0);
        start_miss(18'h2A, 8'h05, 2'd2, 1'b0, 18'h0, '0, 1'b0);
        wait_fills(1, 100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL clean_timeout: got %0d fills expected 1", fill_cyc_q.size()); return; end
        bad = diff_txns();
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL clean_words: got %0d bad of %0d words expected 0", bad, txq.size()); end
        n_checks++; if (acc_q.size() !== 1 || fill_cyc_q[0] !== acc_q[0] + WORDS + 1) begin
            n_fail++; $display("FAIL clean_latency: got fill at %0d expected %0d", fill_cyc_q[0], acc_q[0] + WORDS + 1); end
        n_checks++; if (fill_way_q[0] !== 2'd2 || fill_idx_q[0] !== 8'h05 || fill_tag_q[0] !== 18'h2A) begin
            n_fail++; $display("FAIL clean_fill_id: got way=%0d idx=%h tag=%h expected 2/05/2a", fill_way_q[0], fill_idx_q[0], fill_tag_q[0]); end
        n_checks++; if (fill_line_q[0] !== model_line()) begin
            n_fail++; $display("FAIL clean_line: got %h expected %h", fill_line_q[0], model_line()); end
        n_checks++; if (o_miss_ready !== 1'b0 || o_busy !== 1'b1) begin
            n_fail++; $display("FAIL clean_fill_busy: got ready=%b busy=%b expected 0/1", o_miss_ready, o_busy); end
        @(negedge clk); #2;
        n_checks++; if (o_miss_ready !== 1'b1 || o_fill_valid !== 1'b0) begin
            n_fail++; $display("FAIL clean_ready_again: got ready=%b fill=%b expected 1/0", o_miss_ready, o_fill_valid); end
    endtask

    task automatic test_dirty_miss();
        bit ok; int bad; logic [LB-1:0] vl; logic [17:0] t;
        for (int i = 0; i < WORDS; i++) vl[i*DW +: DW] = 32'(i);
        t = 18'($urandom);
        ack_mode = 0; clear_obs();
        model_miss(t, 8'h05, 1'b1, 18'h11, vl);
        start_miss(t, 8'h05, 2'd1, 1'b1, 18'h11, vl, 1'b0);
        wait_fills(1, 150, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL dirty_timeout: got %0d fills expected 1", fill_cyc_q.size()); return; end
        bad = diff_txns();
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL dirty_words: got %0d bad of %0d words expected 0", bad, txq.size()); end
        n_checks++; if (txq.size() > 0 && txq[0].addr !== 32'h00044140) begin
            n_fail++; $display("FAIL dirty_first_addr: got %h expected 00044140", txq[0].addr); end
        n_checks++; if (acc_q.size() !== 1 || fill_cyc_q[0] !== acc_q[0] + 2*WORDS + 1) begin
            n_fail++; $display("FAIL dirty_latency: got fill at %0d expected %0d", fill_cyc_q[0], acc_q[0] + 2*WORDS + 1); end
        n_checks++; if (fill_line_q[0] !== model_line() || fill_way_q[0] !== 2'd1 || fill_tag_q[0] !== t) begin
            n_fail++; $display("FAIL dirty_fill: got way=%0d tag=%h expected 1/%h", fill_way_q[0], fill_tag_q[0], t); end
    endtask

    task automatic test_ack_stall();
        bit ok; int bad; logic [LB-1:0] vl; logic [17:0] t, vt; logic [7:0] ix;
        for (int i = 0; i < WORDS; i++) vl[i*DW +: DW] = $urandom;
        t = 18'($urandom); vt = 18'($urandom); ix = 8'($urandom);
        ack_mode = 1; clear_obs();
        model_miss(t, ix, 1'b1, vt, vl);
        start_miss(t, ix, 2'd3, 1'b1, vt, vl, 1'b0);
        wait_fills(1, 300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_timeout: got %0d fills expected 1", fill_cyc_q.size()); return; end
        bad = diff_txns();
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL stall_words: got %0d bad of %0d words expected 0", bad, txq.size()); end
        n_checks++; if (hold_err !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", hold_err); end
        n_checks++; if (acc_q.size() !== 1 || fill_cyc_q[0] !== acc_q[0] + 3*2*WORDS + 1) begin
            n_fail++; $display("FAIL stall_latency: got fill at %0d expected %0d", fill_cyc_q[0], acc_q[0] + 6*WORDS + 1); end
        n_checks++; if (fill_line_q[0] !== model_line()) begin
            n_fail++; $display("FAIL stall_line: got %h expected %h", fill_line_q[0], model_line()); end
        ack_mode = 0;
    endtask

    task automatic test_reset_mid_fetch();
        bit ok; int k; int bad; logic [17:0] t; logic [7:0] ix;
        t = 18'($urandom); ix = 8'($urandom);
        ack_mode = 0; clear_obs();
        start_miss(t, ix, 2'd0, 1'b0, 18'h0, '0, 1'b0);
        k = 0;
        while (txq.size() < 7 && k < 50) begin @(negedge clk); #2; k++; end
        @(negedge clk);
        rst = 1'b1;
        #2;
        n_checks++; if (o_mem_req !== 1'b1 || o_mem_addr !== word_addr(t, ix, 7)) begin
            n_fail++; $display("FAIL rst_word7: got req=%b addr=%h expected 1/%h", o_mem_req, o_mem_addr, word_addr(t, ix, 7)); end
        @(negedge clk); #2;
        n_checks++; if (o_mem_req !== 1'b0 || o_busy !== 1'b0 || o_miss_ready !== 1'b1 || o_mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL rst_abandon: got req=%b busy=%b ready=%b addr=%h expected 0/0/1/0", o_mem_req, o_busy, o_miss_ready, o_mem_addr); end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        n_checks++; if (fill_cyc_q.size() !== 0) begin n_fail++; $display("FAIL rst_no_fill: got %0d fills expected 0", fill_cyc_q.size()); end
        clear_obs();
        model_miss(t ^ 18'h1, ix, 1'b0, 18'h0, '0);
        start_miss(t ^ 18'h1, ix, 2'd1, 1'b0, 18'h0, '0, 1'b0);
        wait_fills(1, 100, ok);
        bad = diff_txns();
        n_checks++; if (!ok || bad !== 0 || fill_line_q[0] !== model_line()) begin
            n_fail++; $display("FAIL rst_recover: got fills=%0d bad=%0d expected 1/0", fill_cyc_q.size(), bad); end
    endtask

    task automatic test_hold_valid_spurious_ack();
        bit ok; int bad; int busy_seen = 0; logic [17:0] t; logic [7:0] ix;
        t = 18'($urandom); ix = 8'($urandom);
        ack_mode = 0; clear_obs();
        repeat (5) begin @(negedge clk); #2; if (o_busy !== 1'b0) busy_seen++; end
        n_checks++; if (busy_seen !== 0 || txq.size() !== 0) begin
            n_fail++; $display("FAIL spurious_ack: got busy=%0d words=%0d expected 0/0", busy_seen, txq.size()); end
        model_miss(t, ix, 1'b0, 18'h0, '0);
        start_miss(t, ix, 2'd2, 1'b0, 18'h0, '0, 1'b1);
        wait_fills(1, 100, ok);
        i_miss_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        bad = diff_txns();
        n_checks++; if (!ok || acc_q.size() !== 1 || bad !== 0) begin
            n_fail++; $display("FAIL single_accept: got accepts=%0d bad=%0d expected 1/0", acc_q.size(), bad); end
        n_checks++; if (o_busy !== 1'b0 || fill_cyc_q.size() !== 1) begin
            n_fail++; $display("FAIL single_fill: got busy=%b fills=%0d expected 0/1", o_busy, fill_cyc_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit ok; int bad; logic [LB-1:0] vl; logic [17:0] t, vt; logic [7:0] ix; logic [1:0] w; logic d;
        ack_mode = 2;
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < WORDS; i++) vl[i*DW +: DW] = $urandom;
            t = 18'($urandom); vt = 18'($urandom); ix = 8'($urandom); w = 2'($urandom); d = 1'($urandom);
            clear_obs();
            model_miss(t, ix, d, vt, vl);
            start_miss(t, ix, w, d, vt, vl, 1'b0);
            wait_fills(1, 600, ok);
            bad = diff_txns();
            n_checks++; if (!ok || bad !== 0 || hold_err !== 0) begin
                n_fail++; $display("FAIL b2b_%0d_words: got fills=%0d bad=%0d hold=%0d expected 1/0/0", n, fill_cyc_q.size(), bad, hold_err); end
            n_checks++; if (!ok || fill_line_q[0] !== model_line() || fill_idx_q[0] !== ix || fill_way_q[0] !== w || fill_tag_q[0] !== t) begin
                n_fail++; $display("FAIL b2b_%0d_fill: got idx=%h way=%0d tag=%h expected %h/%0d/%h", n, fill_idx_q[0], fill_way_q[0], fill_tag_q[0], ix, w, t); end
            @(negedge clk);
        end
        ack_mode = 0;
    endtask

    initial begin
        rst = 1'b1; i_miss_valid = 1'b0; i_miss_tag = '0; i_miss_index = '0;
        i_victim_way = '0; i_victim_dirty = 1'b0; i_victim_tag = '0; i_victim_line = '0;
        i_mem_ack = 1'b0; i_mem_rdata = '0;
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_ack_stall();
        test_reset_mid_fetch();
        test_hold_valid_spurious_ack();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
